// File: rtl/rf_cmd_ctrl.sv
`timescale 1ns/1ps
// rf_cmd_ctrl
// Byte-oriented command decoder that sits between a receive byte stream and
// a register file, and returns read data to a transmit buffer.
//
// Command formats (one byte per RX_D_VLD strobe):
//   write : 0xAA, addr, data  -> one WrEn pulse with Address/WrData
//   read  : 0xBB, addr        -> one RdEn pulse, wait for RdData_valid,
//                                then one TX_D_VLD pulse with the read byte
// Unknown opcodes, out-of-range addresses and read timeouts raise a
// one-cycle CMD_ERR pulse and return to IDLE.
//
// Ports:
//   CLK, RST_n          clock (rising edge), asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle strobe
//   RdData/RdData_valid register-file read data and its strobe
//   FIFO_FULL           transmit buffer full (holds the response)
//   WrEn/RdEn           register-file write / read enable pulses
//   Address/WrData      register-file address and write data (held)
//   TX_P_DATA/TX_D_VLD  response byte (held) and its one-cycle strobe
//   CMD_ERR             one-cycle error pulse
// Every output comes straight from a register.

module rf_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_valid,
  input  logic                  FIFO_FULL,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);

  // Counter only needs to reach RD_TIMEOUT-1: the timeout fires on the
  // RD_TIMEOUT-th cycle spent in RD_WAIT without read data.
  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    wr_en_reg, wr_en_next;
  logic                    rd_en_reg, rd_en_next;
  logic [ADDR_WIDTH-1:0]   address_reg, address_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
  logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
  logic                    tx_vld_reg, tx_vld_next;
  logic                    cmd_err_reg, cmd_err_next;
  logic                    addr_ok;

  // An address byte is legal only if no bit above the address field is set.
  assign addr_ok = ((RX_P_DATA >> ADDR_WIDTH) == '0);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      address_reg <= '0;
      wr_data_reg <= '0;
      tx_data_reg <= '0;
      tx_vld_reg  <= 1'b0;
      cmd_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wr_en_reg   <= wr_en_next;
      rd_en_reg   <= rd_en_next;
      address_reg <= address_next;
      wr_data_reg <= wr_data_next;
      tx_data_reg <= tx_data_next;
      tx_vld_reg  <= tx_vld_next;
      cmd_err_reg <= cmd_err_next;
    end
  end

  always_comb begin
    // Pulses default low; data registers default to holding their value.
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    wr_en_next   = 1'b0;
    rd_en_next   = 1'b0;
    address_next = address_reg;
    wr_data_next = wr_data_reg;
    tx_data_next = tx_data_reg;
    tx_vld_next  = 1'b0;
    cmd_err_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == OP_WR)      state_next = WR_ADDR;
          else if (RX_P_DATA == OP_RD) state_next = RD_ADDR;
          else                         cmd_err_next = 1'b1;
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            address_next = RX_P_DATA[ADDR_WIDTH-1:0];
            state_next   = WR_DATA;
          end else begin
            cmd_err_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_next = RX_P_DATA;
          wr_en_next   = 1'b1;
          state_next   = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            address_next = RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_next   = 1'b1;
            cnt_next     = '0;
            state_next   = RD_WAIT;
          end else begin
            cmd_err_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end

      // RX bytes arriving here and in TX_SEND are deliberately not looked at.
      RD_WAIT: begin
        if (RdData_valid) begin
          tx_data_next = RdData;
          state_next   = TX_SEND;
        end else if (cnt_reg == CNT_LAST) begin
          cmd_err_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      TX_SEND: begin
        if (!FIFO_FULL) begin
          tx_vld_next = 1'b1;
          state_next  = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign WrEn      = wr_en_reg;
  assign RdEn      = rd_en_reg;
  assign Address   = address_reg;
  assign WrData    = wr_data_reg;
  assign TX_P_DATA = tx_data_reg;
  assign TX_D_VLD  = tx_vld_reg;
  assign CMD_ERR   = cmd_err_reg;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
`timescale 1ns/1ps
// Directed testbench for rf_cmd_ctrl. Inputs change 1 ns after a rising
// edge, outputs are sampled at the same point, so each sample reflects the
// edge just taken. Pulse counters run on the falling edge.

module tb_rf_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RdData = 8'h00;
  logic       RdData_valid = 1'b0;
  logic       FIFO_FULL = 1'b0;
  logic       WrEn, RdEn, TX_D_VLD, CMD_ERR;
  logic [3:0] Address;
  logic [7:0] WrData, TX_P_DATA;

  int checks = 0;
  int errors = 0;

  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int wr0, rd0, tx0, err0;

  always #5 CLK = ~CLK;

  rf_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(4)) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .RdData       (RdData),
    .RdData_valid (RdData_valid),
    .FIFO_FULL    (FIFO_FULL),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .CMD_ERR      (CMD_ERR)
  );

  always @(negedge CLK) begin
    if (WrEn)         wr_cnt      <= wr_cnt + 1;
    if (RdEn)         rd_cnt      <= rd_cnt + 1;
    if (TX_D_VLD)     tx_cnt      <= tx_cnt + 1;
    if (CMD_ERR)      err_cnt     <= err_cnt + 1;
    if (WrEn && RdEn) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick(1);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic rd_pulse(input logic [7:0] d);
    RdData       = d;
    RdData_valid = 1'b1;
    tick(1);
    RdData_valid = 1'b0;
  endtask

  task automatic snap();
    wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt; err0 = err_cnt;
  endtask

  initial begin
    // ---- reset state ----
    #3;
    chk("rst_wren",    32'(WrEn),      32'd0);
    chk("rst_rden",    32'(RdEn),      32'd0);
    chk("rst_addr",    32'(Address),   32'd0);
    chk("rst_wrdata",  32'(WrData),    32'd0);
    chk("rst_txdata",  32'(TX_P_DATA), 32'd0);
    chk("rst_txvld",   32'(TX_D_VLD),  32'd0);
    chk("rst_cmderr",  32'(CMD_ERR),   32'd0);
    tick(2);
    RST_n = 1'b1;
    tick(1);

    // ---- write 0xAA,0x05,0x3C ----
    snap();
    send(8'hAA);
    send(8'h05);
    send(8'h3C);
    chk("wr_wren",   32'(WrEn),   32'd1);
    chk("wr_addr",   32'(Address), 32'd5);
    chk("wr_data",   32'(WrData), 32'h3C);
    tick(3);
    chk("wr_wren_low",  32'(WrEn),          32'd0);
    chk("wr_pulses",    32'(wr_cnt - wr0),  32'd1);
    chk("wr_no_err",    32'(err_cnt - err0), 32'd0);
    chk("wr_addr_hold", 32'(Address),       32'd5);

    // ---- read 0xBB,0x02 with data one cycle after RdEn ----
    snap();
    send(8'hBB);
    send(8'h02);
    chk("rd_rden", 32'(RdEn),    32'd1);
    chk("rd_addr", 32'(Address), 32'd2);
    tick(1);
    rd_pulse(8'h81);
    chk("rd_capture", 32'(TX_P_DATA), 32'h81);
    chk("rd_txvld_wait", 32'(TX_D_VLD), 32'd0);
    tick(1);
    chk("rd_txvld", 32'(TX_D_VLD),  32'd1);
    chk("rd_txdata", 32'(TX_P_DATA), 32'h81);
    tick(3);
    chk("rd_tx_pulses", 32'(tx_cnt - tx0), 32'd1);
    chk("rd_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    chk("rd_wr_pulses", 32'(wr_cnt - wr0), 32'd0);

    // ---- backpressure: FIFO_FULL for 10 cycles ----
    snap();
    FIFO_FULL = 1'b1;
    send(8'hBB);
    send(8'h02);
    tick(1);
    RdData       = 8'h81;
    RdData_valid = 1'b1;
    tick(1);
    RdData_valid = 1'b0;
    // FIFO_FULL was sampled high at this edge: first of the 10 full cycles
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold_%0d", i), 32'(TX_D_VLD), 32'd0);
      if (i < 9) tick(1);
    end
    FIFO_FULL = 1'b0;
    tick(1);
    chk("bp_txvld",  32'(TX_D_VLD),  32'd1);
    chk("bp_txdata", 32'(TX_P_DATA), 32'h81);
    tick(2);
    chk("bp_tx_pulses", 32'(tx_cnt - tx0), 32'd1);

    // ---- bad opcode ----
    snap();
    send(8'h12);
    chk("badop_err", 32'(CMD_ERR), 32'd1);
    tick(1);
    chk("badop_err_low", 32'(CMD_ERR), 32'd0);

    // ---- bad write address ----
    send(8'hAA);
    chk("badaddr_err_op", 32'(CMD_ERR), 32'd0);
    send(8'h15);
    chk("badaddr_err",  32'(CMD_ERR), 32'd1);
    chk("badaddr_wren", 32'(WrEn),    32'd0);
    send(8'h3C); // must be taken as an opcode -> error
    chk("badaddr_idle", 32'(CMD_ERR), 32'd1);
    tick(2);
    chk("badaddr_wr_pulses", 32'(wr_cnt - wr0), 32'd0);

    // ---- read timeout ----
    snap();
    send(8'hBB);
    send(8'h01);
    chk("to_rden", 32'(RdEn), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk($sformatf("to_wait_%0d", i), 32'(CMD_ERR), 32'd0);
    end
    tick(1);
    chk("to_err", 32'(CMD_ERR), 32'd1);
    // back-to-back: next opcode on the very next cycle
    send(8'hAA);
    send(8'h0A);
    send(8'h55);
    chk("b2b_wren", 32'(WrEn),    32'd1);
    chk("b2b_addr", 32'(Address), 32'hA);
    chk("b2b_data", 32'(WrData),  32'h55);
    tick(2);
    chk("to_tx_pulses", 32'(tx_cnt - tx0),  32'd0);
    chk("to_err_pulses", 32'(err_cnt - err0), 32'd1);

    // ---- reset mid-command ----
    snap();
    send(8'hAA);
    send(8'h07);
    RST_n = 1'b0;
    #2;
    chk("mid_rst_addr",   32'(Address),   32'd0);
    chk("mid_rst_wrdata", 32'(WrData),    32'd0);
    chk("mid_rst_txdata", 32'(TX_P_DATA), 32'd0);
    chk("mid_rst_wren",   32'(WrEn),      32'd0);
    chk("mid_rst_cmderr", 32'(CMD_ERR),   32'd0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    send(8'h3C);
    chk("post_rst_err",  32'(CMD_ERR), 32'd1);
    chk("post_rst_wren", 32'(WrEn),    32'd0);
    tick(2);
    chk("post_rst_wr_pulses", 32'(wr_cnt - wr0), 32'd0);

    // ---- byte during RD_WAIT is dropped ----
    snap();
    send(8'hBB);
    send(8'h03);
    send(8'hAA);
    chk("drop_no_err", 32'(CMD_ERR), 32'd0);
    rd_pulse(8'h5A);
    tick(1);
    chk("drop_txvld",  32'(TX_D_VLD),  32'd1);
    chk("drop_txdata", 32'(TX_P_DATA), 32'h5A);
    chk("drop_addr",   32'(Address),   32'd3);
    tick(2);
    chk("drop_err_pulses", 32'(err_cnt - err0), 32'd0);
    chk("drop_wr_pulses",  32'(wr_cnt - wr0),   32'd0);
    chk("drop_txhold",     32'(TX_P_DATA),      32'h5A);

    chk("wren_rden_overlap", 32'(overlap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_cmd_ctrl.md
RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte/data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have parameter RD_TIMEOUT, default 4, max cycles waited for RdData_valid.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port RX_P_DATA  input  DATA_WIDTH  received command byte.
REQ-007 SHALL have port RX_D_VLD  input  1  one-cycle strobe qualifying RX_P_DATA.
REQ-008 SHALL have port RdData  input  DATA_WIDTH  register-file read data.
REQ-009 SHALL have port RdData_valid  input  1  register-file read-data strobe.
REQ-010 SHALL have port FIFO_FULL  input  1  transmit buffer full.
REQ-011 SHALL have port WrEn  output  1  register-file write enable.
REQ-012 SHALL have port RdEn  output  1  register-file read enable.
REQ-013 SHALL have port Address  output  ADDR_WIDTH  register-file address.
REQ-014 SHALL have port WrData  output  DATA_WIDTH  register-file write data.
REQ-015 SHALL have port TX_P_DATA  output  DATA_WIDTH  response byte.
REQ-016 SHALL have port TX_D_VLD  output  1  one-cycle strobe qualifying TX_P_DATA.
REQ-017 SHALL have port CMD_ERR  output  1  one-cycle error pulse.

Function
REQ-018 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND; all outputs registered.
REQ-019 IDLE: RX_D_VLD with 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> CMD_ERR high next cycle, stay IDLE.
REQ-020 WR_ADDR/RD_ADDR: on RX_D_VLD, byte bits above ADDR_WIDTH-1 nonzero -> CMD_ERR pulse, return IDLE, no WrEn/RdEn.
REQ-021 WR_ADDR: valid address byte latched into Address -> WR_DATA.
REQ-022 WR_DATA: on RX_D_VLD, WrData=byte and WrEn=1 for exactly the next cycle, Address held -> IDLE.
REQ-023 RD_ADDR: valid address byte latched into Address, RdEn=1 for exactly the next cycle -> RD_WAIT.
REQ-024 RD_WAIT: cycle counter cleared on entry; RdData_valid=1 -> RdData captured into TX_P_DATA holding register -> TX_SEND.
REQ-025 RD_WAIT: RD_TIMEOUT cycles elapse without RdData_valid -> CMD_ERR pulse -> IDLE.
REQ-026 TX_SEND: FIFO_FULL=0 -> TX_D_VLD=1 one cycle with captured byte -> IDLE; FIFO_FULL=1 -> hold state, TX_D_VLD=0, byte retained.
REQ-027 RX_D_VLD in RD_WAIT or TX_SEND SHALL be ignored: byte dropped, no state change, no CMD_ERR.
REQ-028 WrEn and RdEn SHALL never be high in the same cycle; each is high at most one cycle per command.
REQ-029 Address/WrData SHALL hold last value between commands; TX_P_DATA holds last sent byte.
REQ-030 Back-to-back commands: next opcode byte accepted the cycle after return to IDLE; no dead cycles required.

Reset
REQ-031 RST_n low SHALL force IDLE and zero WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, timeout counter, immediately.
REQ-032 Reset mid-command SHALL abort it: no WrEn/RdEn/TX_D_VLD after deassertion until a new full command.
REQ-033 First edge after RST_n rises SHALL treat state as IDLE.

Verification
REQ-034 Write: bytes 0xAA,0x05,0x3C -> one WrEn pulse, Address=5, WrData=0x3C, no CMD_ERR.
REQ-035 Read: 0xBB,0x02, RdData_valid with RdData=0x81 one cycle after RdEn, FIFO_FULL=0 -> one TX_D_VLD, TX_P_DATA=0x81.
REQ-036 Backpressure: read as REQ-035 with FIFO_FULL=1 for 10 cycles -> TX_D_VLD stays 0, asserts once in cycle after FIFO_FULL falls, value 0x81.
REQ-037 Errors: opcode 0x12 -> CMD_ERR one pulse, IDLE; 0xAA,0x15 -> CMD_ERR, no WrEn; 0xBB,0x01 with no RdData_valid -> CMD_ERR after 4 cycles.
REQ-038 Reset: RST_n low after 0xAA,0x07 -> next 0x3C produces CMD_ERR (treated as opcode), no WrEn; all outputs 0 during reset.
REQ-039 Dropped bytes: 0xBB,0x03 then 0xAA during RD_WAIT -> 0xAA ignored, read completes normally.
